// File: rtl/serial_adder_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl_pkg
// Shared definitions for the bit-serial adder controller:
//   - state_e   : FSM state encoding (IDLE / RUN / DONE)
//   - cnt_width : bit-counter width for a given operand width (minimum 1)
// ---------------------------------------------------------------------------
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter must index bits 0..width-1; a 1-bit operand still needs a
    // 1-bit counter so the vector declaration stays legal.
    function automatic int cnt_width(input int width);
        if (width > 1) begin
            return $clog2(width);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/adder_1b.sv
// ---------------------------------------------------------------------------
// adder_1b
// Single-bit full adder, purely combinational.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   sum   : a ^ b ^ cin
//   cout  : majority(a, b, cin)
// ---------------------------------------------------------------------------
module adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder_ctrl_chk.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl_chk
// Protocol checker for serial_adder_ctrl outputs (simulation only).
// Ports:
//   clk, rst          : same clock/reset as the checked instance
//   busy, done        : handshake outputs
//   sum, cout         : result outputs
// ---------------------------------------------------------------------------
module serial_adder_ctrl_chk #(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    input logic             busy,
    input logic             done,
    input logic [WIDTH-1:0] sum,
    input logic             cout
);

    // busy and done are never high together.
    a_excl: assert property (@(posedge clk) disable iff (rst) !(busy && done));

    // done is a single-cycle pulse.
    a_pulse: assert property (@(posedge clk) disable iff (rst) done |=> !done);

    // Results only move at completion.
    a_hold: assert property (@(posedge clk) disable iff (rst)
        busy |=> (done || ($stable(sum) && $stable(cout))));

    // Reset returns every output to zero.
    a_rst: assert property (@(posedge clk)
        rst |=> (!busy && !done && (sum == '0) && !cout));

endmodule

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial WIDTH-bit adder. One adder_1b is stepped over WIDTH cycles,
// LSB first, with the carry held in a register between bits. A host issues
// one addition at a time with start and sees busy during processing and a
// one-cycle done pulse when sum/cout have just been updated.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   start  : request, only honoured in IDLE
//   a, b   : operands, captured on accepted start
//   cin    : carry in, captured on accepted start
//   busy   : high while bits are being processed
//   done   : one-cycle pulse, result just updated
//   sum    : registered result (a+b+cin) mod 2^WIDTH
//   cout   : registered carry out of the MSB
// ---------------------------------------------------------------------------
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] part_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] a_sh_d;
    logic [WIDTH-1:0] b_sh_d;
    logic [WIDTH-1:0] part_d;
    logic             add_sum_s;
    logic             add_cout_s;

    // The only arithmetic in the block: one full adder on the current LSBs.
    adder_1b u_adder_1b (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    assign a_sh_d = a_sh_q >> 1'b1;
    assign b_sh_d = b_sh_q >> 1'b1;

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 of the
    // operands has travelled down to bit 0 of the partial result.
    generate
        if (WIDTH > 1) begin : g_part_wide
            assign part_d = {add_sum_s, part_q[WIDTH-1:1]};
        end else begin : g_part_one
            assign part_d = add_sum_s;
        end
    endgenerate

    // Control FSM, datapath registers and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            part_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        part_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sh_q  <= a_sh_d;
                    b_sh_q  <= b_sh_d;
                    part_q  <= part_d;
                    carry_q <= add_cout_s;
                    cnt_q   <= cnt_q + CNT_ONE;
                    // Results are published only here, on the last bit.
                    if (cnt_q == CNT_LAST) begin
                        sum_q   <= part_d;
                        cout_q  <= add_cout_s;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    // start is deliberately not looked at here.
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, cin, busy, done, cout;
    logic [7:0] a, b, sum;

    logic       start1, a1, b1, cin1, busy1, done1, sum1, cout1;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    serial_adder_ctrl_chk #(.WIDTH(8)) chk8 (
        .clk(clk), .rst(rst), .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder_ctrl_chk #(.WIDTH(1)) chk1 (
        .clk(clk), .rst(rst), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         done_cnt = 0;
    logic [8:0] exp_q[$];
    logic [1:0] exp1_q[$];
    logic [8:0] e8;
    logic [1:0] e1;
    logic [7:0] last_sum = 8'h00;
    logic       last_cout = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Scoreboard monitor for the 8-bit instance.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: sum=%0h cout=%0b with no result pending", sum, cout);
            end else begin
                e8 = exp_q.pop_front();
                check("result8", {23'd0, cout, sum}, {23'd0, e8});
                check("busy_low_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Scoreboard monitor for the 1-bit instance.
    always @(negedge clk) begin
        if (done1) begin
            if (exp1_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done1: sum=%0b cout=%0b with no result pending", sum1, cout1);
            end else begin
                e1 = exp1_q.pop_front();
                check("result1", {30'd0, cout1, sum1}, {30'd0, e1});
            end
        end
    end

    // One full operation on the 8-bit instance with hand-supplied expectation.
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                          input logic [7:0] es, input logic ec);
        int nb;
        bit seen;
        @(negedge clk);
        a = av; b = bv; cin = cv; start = 1'b1;
        exp_q.push_back({ec, es});
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) nb++;
                check("hold_during_run", {23'd0, cout, sum}, {23'd0, last_cout, last_sum});
                @(negedge clk);
            end
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        check("busy_cycles", nb, 32'd8);
        @(negedge clk);
        check("done_single_pulse", {31'd0, done}, 32'd0);
        last_sum = es;
        last_cout = ec;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int dc0, nd;
        int t[3];
        bit seen;
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] rs;

        // 1. Reset with start held high.
        rst = 1'b1; start = 1'b1; a = 8'h35; b = 8'h4A; cin = 1'b1;
        start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        rst = 1'b0; start = 1'b0; start1 = 1'b0;
        @(negedge clk);
        check("no_op_after_rst", {31'd0, busy}, 32'd0);

        // 2. Basic add.
        run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);

        // 3. Overflow cases.
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // 4. start and input changes during RUN are ignored.
        dc0 = done_cnt;
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        exp_q.push_back({1'b0, 8'h30});
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; cin = 1'b0;
        repeat (14) @(negedge clk);
        check("single_done", done_cnt - dc0, 32'd1);
        check("idle_after_ignored_start", {31'd0, busy}, 32'd0);
        last_sum = 8'h30; last_cout = 1'b0;

        // 5. Reset in RUN cycle 4 aborts without done.
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_sum", {24'd0, sum}, 32'd0);
        check("abort_cout", {31'd0, cout}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        dc0 = done_cnt;
        repeat (12) @(negedge clk);
        check("no_done_after_abort", done_cnt - dc0, 32'd0);
        last_sum = 8'h00; last_cout = 1'b0;
        run_op(8'h01, 8'h01, 1'b1, 8'h03, 1'b0);

        // 6. start held high: back-to-back issue every 10 cycles.
        @(negedge clk);
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        repeat (3) exp_q.push_back({1'b1, 8'h00});
        nd = 0;
        for (int k = 0; k < 60 && nd < 3; k++) begin
            @(negedge clk);
            if (done) begin
                t[nd] = k;
                nd++;
                if (nd == 3) start = 1'b0;
            end
        end
        check("free_run_dones", nd, 32'd3);
        check("issue_interval_1", t[1] - t[0], 32'd10);
        check("issue_interval_2", t[2] - t[1], 32'd10);
        repeat (4) @(negedge clk);
        check("idle_after_free_run", {31'd0, busy}, 32'd0);
        last_sum = 8'h00; last_cout = 1'b1;

        // Random vectors on WIDTH=8 against plain addition.
        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            rs = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            run_op(ra, rb, rc, rs[7:0], rs[8]);
        end

        // Exhaustive WIDTH=1.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a1 = i[2]; b1 = i[1]; cin1 = i[0]; start1 = 1'b1;
            exp1_q.push_back({1'b0, a1} + {1'b0, b1} + {1'b0, cin1});
            @(negedge clk);
            start1 = 1'b0;
            check("w1_busy", {31'd0, busy1}, 32'd1);
            seen = 1'b0;
            for (int k = 0; k < 5 && !seen; k++) begin
                @(negedge clk);
                if (done1) seen = 1'b1;
            end
            check("w1_done_seen", {31'd0, seen}, 32'd1);
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("queue8_empty", exp_q.size(), 32'd0);
        check("queue1_empty", exp1_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
